// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI constants and receiver state encoding
package spi_pkg;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} rx_state_t;
endpackage

// File: rtl/spi_slave_rx_if.sv
// rtl/spi_slave_rx_if.sv - SPI pins plus received-word valid/ready port
interface spi_slave_rx_if #(parameter int DATA_W = spi_pkg::DATA_W);
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              frame_err;
  logic              overrun;

  modport master (
    output sclk, cs, mosi, dout_ready,
    input  dout, dout_valid, frame_err, overrun
  );

  modport slave (
    input  sclk, cs, mosi, dout_ready,
    output dout, dout_valid, frame_err, overrun
  );
endinterface

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with registered edge pulses
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  // Edge pulses are registered, adding one cycle after sync_out changes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

  assign sync_out = r_sync[SYNC_STAGES-1];
  assign rise     = r_rise;
  assign fall     = r_fall;
endmodule

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI receive endpoint: LSB-first word assembly onto valid/ready
module spi_slave_rx #(
  parameter int DATA_W      = spi_pkg::DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  spi_slave_rx_if.slave bus
);
  import spi_pkg::*;

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic w_sclk_fall;
  logic w_cs_s;
  logic w_mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .async_in(bus.sclk), .sync_out(), .rise(), .fall(w_sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .async_in(bus.cs), .sync_out(w_cs_s), .rise(), .fall()
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .async_in(bus.mosi), .sync_out(w_mosi_s), .rise(), .fall()
  );

  rx_state_t         r_state, w_state;
  logic [DATA_W-1:0] r_shreg, w_shreg;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [DATA_W-1:0] r_dout, w_dout;
  logic              r_dout_valid, w_dout_valid;
  logic              r_frame_err, w_frame_err;
  logic              r_overrun, w_overrun;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_shreg      <= w_shreg;
      r_cnt        <= w_cnt;
      r_dout       <= w_dout;
      r_dout_valid <= w_dout_valid;
      r_frame_err  <= w_frame_err;
      r_overrun    <= w_overrun;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_shreg      = r_shreg;
    w_cnt        = r_cnt;
    w_dout       = r_dout;
    w_dout_valid = r_dout_valid;
    w_frame_err  = 1'b0;
    w_overrun    = 1'b0;

    if (r_dout_valid && bus.dout_ready) w_dout_valid = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (!w_cs_s) w_state = SHIFT;
      end
      SHIFT: begin
        if (w_sclk_fall) begin
          w_shreg = {w_mosi_s, r_shreg[DATA_W-1:1]};
          if (r_cnt == LAST_BIT) begin
            w_cnt   = '0;
            w_state = LOAD;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end else if (w_cs_s) begin
          w_frame_err = (r_cnt != '0);
          w_cnt       = '0;
          w_state     = IDLE;
        end
      end
      LOAD: begin
        // A word being consumed this very cycle frees the slot for the new one.
        if (!r_dout_valid || bus.dout_ready) begin
          w_dout       = r_shreg;
          w_dout_valid = 1'b1;
        end else begin
          w_overrun = 1'b1;
        end
        w_state = w_cs_s ? IDLE : SHIFT;
      end
      default: w_state = IDLE;
    endcase
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - self-checking bench for spi_slave_rx
module tb_spi_slave_rx;
  localparam int W  = spi_pkg::DATA_W;
  localparam int HP = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_slave_rx_if #(.DATA_W(W)) bus ();
  spi_slave_rx #(.DATA_W(W), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] got_q[$];
  int ferr_cnt = 0;
  int ovr_cnt  = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.dout_valid && bus.dout_ready) got_q.push_back(bus.dout);
      if (bus.frame_err) ferr_cnt++;
      if (bus.overrun) ovr_cnt++;
    end
  end

  typedef struct {
    logic [63:0] data;
    int          nbits;
    int          exp_words;
    logic [W-1:0] exp_dout;
    int          exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
  endtask

  task automatic spi_bits(input logic [63:0] d, input int nbits, input bit release_cs);
    bus.cs = 1'b0;
    clk_wait(HP);
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = d[i];
      bus.sclk = 1'b1;
      clk_wait(HP);
      bus.sclk = 1'b0;
      clk_wait(HP);
    end
    if (release_cs) begin
      bus.cs = 1'b1;
      clk_wait(2 * HP);
    end
  endtask

  vec_t vecs[7];
  logic [W-1:0] exp_q[$];
  int exp_ferr;

  initial begin
    bus.sclk = 1'b0;
    bus.cs = 1'b1;
    bus.mosi = 1'b0;
    bus.dout_ready = 1'b1;
    clk_wait(3);
    check("reset_dout", 32'(bus.dout), 32'h0);
    check("reset_valid", 32'(bus.dout_valid), 32'h0);
    check("reset_ferr", 32'(bus.frame_err), 32'h0);
    check("reset_ovr", 32'(bus.overrun), 32'h0);
    rst = 1'b1;
    clk_wait(5);

    vecs[0] = '{64'hA5C, 12, 1, 12'hA5C, 0};
    vecs[1] = '{64'hFFF, 5, 0, 12'h000, 1};
    vecs[2] = '{64'h0F0, 12, 1, 12'h0F0, 0};
    vecs[3] = '{64'h000, 12, 1, 12'h000, 0};
    vecs[4] = '{64'hFFF, 12, 1, 12'hFFF, 0};
    vecs[5] = '{64'h001, 11, 0, 12'h000, 1};
    vecs[6] = '{64'h000, 0, 0, 12'h000, 0};
    for (int v = 0; v < 7; v++) begin
      clear_mon();
      spi_bits(vecs[v].data, vecs[v].nbits, 1'b1);
      check($sformatf("vec%0d_words", v), 32'(got_q.size()), 32'(vecs[v].exp_words));
      if (vecs[v].exp_words == 1 && got_q.size() == 1)
        check($sformatf("vec%0d_dout", v), 32'(got_q[0]), 32'(vecs[v].exp_dout));
      check($sformatf("vec%0d_ferr", v), 32'(ferr_cnt), 32'(vecs[v].exp_ferr));
      check($sformatf("vec%0d_ovr", v), 32'(ovr_cnt), 32'h0);
      check($sformatf("vec%0d_valid_idle", v), 32'(bus.dout_valid), 32'h0);
    end

    // Latency: final sclk fall sampled at edge N, valid expected after edge N+4.
    clear_mon();
    spi_bits(64'h3C5, W - 1, 1'b0);
    bus.mosi = 1'b0;
    bus.sclk = 1'b1;
    clk_wait(HP);
    bus.sclk = 1'b0;
    @(posedge clk);
    #1;
    clk_wait(3);
    check("lat_n3_valid", 32'(bus.dout_valid), 32'h0);
    clk_wait(1);
    check("lat_n4_valid", 32'(bus.dout_valid), 32'h1);
    check("lat_n4_dout", 32'(bus.dout), 32'h3C5);
    clk_wait(HP);
    bus.cs = 1'b1;
    clk_wait(2 * HP);

    // Backpressure and overrun.
    clear_mon();
    bus.dout_ready = 1'b0;
    spi_bits(64'h123, 12, 1'b1);
    spi_bits(64'h456, 12, 1'b1);
    check("bp_ovr", 32'(ovr_cnt), 32'h1);
    check("bp_dout", 32'(bus.dout), 32'h123);
    check("bp_valid", 32'(bus.dout_valid), 32'h1);
    bus.dout_ready = 1'b1;
    clk_wait(1);
    bus.dout_ready = 1'b0;
    clk_wait(1);
    check("bp_valid_clear", 32'(bus.dout_valid), 32'h0);
    check("bp_consumed", 32'(got_q.size()), 32'h1);
    bus.dout_ready = 1'b1;

    // Back-to-back words in one cs-low frame.
    clear_mon();
    spi_bits({40'h0, 12'h800, 12'h001}, 24, 1'b1);
    check("b2b_words", 32'(got_q.size()), 32'h2);
    if (got_q.size() == 2) begin
      check("b2b_w0", 32'(got_q[0]), 32'h001);
      check("b2b_w1", 32'(got_q[1]), 32'h800);
    end
    check("b2b_ovr", 32'(ovr_cnt), 32'h0);

    // Reset mid-frame.
    clear_mon();
    spi_bits(64'h07F, 7, 1'b0);
    rst = 1'b0;
    bus.cs = 1'b1;
    clk_wait(2);
    rst = 1'b1;
    check("rstmid_dout", 32'(bus.dout), 32'h0);
    check("rstmid_valid", 32'(bus.dout_valid), 32'h0);
    check("rstmid_ferr_out", 32'(bus.frame_err), 32'h0);
    clk_wait(2 * HP);
    check("rstmid_ferr", 32'(ferr_cnt), 32'h0);
    spi_bits(64'h5A5, 12, 1'b1);
    check("rstmid_words", 32'(got_q.size()), 32'h1);
    if (got_q.size() == 1) check("rstmid_dout2", 32'(got_q[0]), 32'h5A5);

    // Randomized frames checked against a word-level model.
    for (int t = 0; t < 25; t++) begin
      logic [63:0] d;
      int nb;
      int r;
      d = {$urandom(), $urandom()};
      r = $urandom_range(0, 9);
      nb = (r < 6) ? 12 : (r < 8) ? 24 : $urandom_range(1, 23);
      clear_mon();
      exp_q.delete();
      for (int k = 0; k + W <= nb; k += W) exp_q.push_back(W'(d >> k));
      exp_ferr = (nb % W != 0) ? 1 : 0;
      spi_bits(d, nb, 1'b1);
      check($sformatf("rnd%0d_words", t), 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
        check($sformatf("rnd%0d_w%0d", t, k), 32'(got_q[k]), 32'(exp_q[k]));
      check($sformatf("rnd%0d_ferr", t), 32'(ferr_cnt), 32'(exp_ferr));
      check($sformatf("rnd%0d_ovr", t), 32'(ovr_cnt), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- Receive-side endpoint for the team's SPI master (`spi`).
- Oversamples the master's sclk, cs and mosi on the local clk.
- Reassembles each DATA_W-bit word, sent LSB first, and presents it on a valid/ready output port.
- Flags frame errors (cs released mid-word) and overruns (new word arrives while the previous one is still unconsumed).
- Used as the DUT-facing responder in SPI loopback benches and as the RX front end of SPI peripherals.

Parameters:
- DATA_W, 12: bits per word; matches the master's din width.
- SYNC_STAGES, 2: flops per input synchronizer; minimum 2.

Ports:
- clk  in  1  system clock; sclk is asynchronous to it.
- rst  in  1  synchronous, active-low reset.
- sclk  in  1  SPI clock from the master; idle low.
- cs  in  1  chip select, active low.
- mosi  in  1  serial data; master drives on sclk rise, this block samples on sclk fall.
- dout  out  DATA_W  received word, LSB = first bit received.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout when dout_valid & dout_ready.
- frame_err  out  1  one-clk pulse when cs deasserts with a partial word.
- overrun  out  1  one-clk pulse when a completed word is dropped.

Behaviour:
- Reset (rst==0 at a clk edge):
  - dout=0, dout_valid=0, frame_err=0, overrun=0.
  - Shift register and bit counter cleared; FSM to IDLE.
  - Synchronizer chains preset: sclk chain 0, cs chain 1, mosi chain 0.
  - Reset mid-frame discards the partial word with no frame_err.
- Synchronization and edge detect:
  - sclk, cs and mosi each pass through SYNC_STAGES flops, giving sclk_s, cs_s and mosi_s.
  - sclk_fall = previous sclk_s high and current sclk_s low.
- Timing requirement on the master: sclk high and low phases each ≥ SYNC_STAGES+3 clk cycles. The master's divide-by-20 sclk meets this.
- FSM:
  - IDLE: bit counter = 0. cs_s==0 → SHIFT.
  - SHIFT, on sclk_fall:
    - shreg = {mosi_s, shreg[DATA_W-1:1]}; bit counter increments.
    - If the counter was DATA_W-1 → LOAD and the counter resets to 0.
  - SHIFT, cs_s==1 seen:
    - With counter != 0: frame_err=1 for one cycle, discard the word, → IDLE.
    - With counter == 0: → IDLE silently.
  - LOAD, single cycle:
    - If dout_valid==0, or dout_valid & dout_ready in this cycle: dout ← shreg, dout_valid ← 1.
    - Otherwise overrun=1 for one cycle; dout keeps the old word and the new word is dropped.
    - Next state: SHIFT if cs_s==0, else IDLE. Back-to-back words under a single cs-low frame are supported.
- Output handshake:
  - dout_valid clears on a clk edge where dout_valid & dout_ready and no LOAD write occurs.
  - dout is stable while dout_valid==1.
- Latency: dout_valid rises SYNC_STAGES+2 clk edges after the first clk edge that samples the final sclk falling edge at the pin.
- sclk_fall while in IDLE (cs high) is ignored.
- cs asserted with no sclk activity causes no output change.

Decomposition:
- Package spi_pkg holds:
  - the DATA_W default constant, shared with the master;
  - typedef enum logic [1:0] {IDLE, SHIFT, LOAD} rx_state_t.
- Sub-module spi_sync_edge(clk, rst, async_in, sync_out, rise, fall), parameterized on SYNC_STAGES and reset value.
  - Instantiated three times: sclk uses fall, cs uses level, mosi uses level.
- Top level holds the FSM, shift register, bit counter and output register.

Test Plan:
- Single word: master sends 12'hA5C with dout_ready=1 → one dout_valid pulse, dout=12'hA5C, frame_err=0, overrun=0.
- Latency check, SYNC_STAGES=2: clk edge sampling the 12th sclk fall at edge N → dout_valid=1 after edge N+4.
- Backpressure:
  - Send 12'h123 with dout_ready=0, then 12'h456 → overrun pulses once; dout stays 12'h123.
  - Then dout_ready=1 for 1 cycle → dout_valid=0.
- Frame error: cs raised after 5 bits of 12'hFFF → frame_err one-cycle pulse, dout_valid stays 0; next full word 12'h0F0 is received correctly.
- Back-to-back: cs held low for 24 sclk cycles carrying 12'h001 then 12'h800, consumer always ready → two valid pulses with those values in order.
- Reset mid-frame: rst=0 for 2 cycles after 7 bits → all outputs 0 and no frame_err; subsequent word 12'h5A5 received correctly.
